// File: rtl/arb4_priority_rr.sv
// Four-requester arbiter: fixed-priority or round-robin selection, grant held until release or hold-limit revoke.
// Latency: 1 cycle from req sampled high (in IDLE) to gnt high; all outputs registered.
// Backpressure: owner keeps gnt while its req stays high; others wait, at least one idle cycle between grants.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset, clears all state immediately
//   req[3:0]   level-sensitive request lines, one per requester
//   rr_en      1 = round-robin, 0 = fixed priority (req[3] highest); sampled only in IDLE
//   gnt[3:0]   one-hot registered grant, zero when no owner
//   gnt_valid  equals |gnt
//   gnt_id     binary index of current owner, keeps last owner while idle
//   timeout    one-cycle pulse when a grant is revoked by the hold limit
//
// MAX_HOLD: 0 disables the hold limit, otherwise 2..255 and must fit in CNT_W bits.
module arb4_priority_rr #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       rr_en,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_id,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam bit               HOLD_EN  = (MAX_HOLD != 0);

  state_t           state_q, state_d;
  logic [3:0]       gnt_d;
  logic             valid_d;
  logic [1:0]       id_d;
  logic             to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;

  logic [1:0]       win_fp;
  logic [1:0]       win_rr;
  logic             rr_found;
  logic [1:0]       rr_idx;
  logic [1:0]       win;

  // Fixed priority: later iterations overwrite, so the highest set index wins.
  always_comb begin
    win_fp = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) win_fp = 2'(i);
    end
  end

  // Round-robin: scan upward from rr pointer with 2-bit wraparound, first hit wins.
  always_comb begin
    win_rr   = ptr_q;
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      rr_idx = ptr_q + 2'(k);
      if (!rr_found && req[rr_idx]) begin
        win_rr   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign win = rr_en ? win_rr : win_fp;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    id_d    = gnt_id;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    to_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = 4'b0001 << win;
          id_d    = win;
          cnt_d   = CNT_W'(1);
          // Pointer advances on every grant, even in fixed mode, so a later
          // switch to round-robin starts just past the last owner.
          ptr_d   = win + 2'd1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!req[gnt_id]) begin
          gnt_d   = 4'b0000;
          state_d = IDLE;
        end else if (HOLD_EN && (cnt_q == HOLD_LIM)) begin
          gnt_d   = 4'b0000;
          to_d    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          // Saturation only matters with the limit disabled; with it enabled
          // the counter never passes HOLD_LIM.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = IDLE;
      end
    endcase

    valid_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
      gnt_id    <= 2'd0;
      timeout   <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      gnt       <= gnt_d;
      gnt_valid <= valid_d;
      gnt_id    <= id_d;
      timeout   <= to_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

endmodule

// File: tb/tb_arb4_priority_rr.sv
// Bench for arb4_priority_rr: table of per-cycle vectors plus hand-written
// sequences for mid-cycle async reset and the disabled hold limit.
// dut uses MAX_HOLD=8; dut0 uses MAX_HOLD=0 and shares all inputs.
module tb_arb4_priority_rr;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rr_en;

  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout;

  logic [3:0] gnt0;
  logic       gnt_valid0;
  logic [1:0] gnt_id0;
  logic       timeout0;

  int n_cmp;
  int n_err;

  arb4_priority_rr #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rr_en     (rr_en),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  arb4_priority_rr #(.MAX_HOLD(0), .CNT_W(8)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rr_en     (rr_en),
    .gnt       (gnt0),
    .gnt_valid (gnt_valid0),
    .gnt_id    (gnt_id0),
    .timeout   (timeout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       rr_en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       to;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic r, input logic e, input logic [3:0] q,
                     input logic [3:0] g, input logic [1:0] id, input logic t,
                     input string nm);
    vec_t v;
    v.rst_n = r;
    v.rr_en = e;
    v.req   = q;
    v.gnt   = g;
    v.id    = id;
    v.to    = t;
    v.name  = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] eg, input logic [1:0] eid,
                         input logic et);
    chk({nm, ".gnt"},       32'(gnt),       32'(eg));
    chk({nm, ".gnt_valid"}, 32'(gnt_valid), 32'(|eg));
    chk({nm, ".gnt_id"},    32'(gnt_id),    32'(eid));
    chk({nm, ".timeout"},   32'(timeout),   32'(et));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m;
    n_cmp = 0;
    n_err = 0;

    // Fixed priority: 0110 -> owner 2 for 5 cycles, then gap, then owner 1.
    row(0, 0, 4'b0000, 4'b0000, 2'd0, 0, "fp_rst");
    row(1, 0, 4'b0000, 4'b0000, 2'd0, 0, "fp_idle");
    row(1, 0, 4'b0110, 4'b0100, 2'd2, 0, "fp_grant");
    for (int i = 0; i < 4; i++) row(1, 0, 4'b0110, 4'b0100, 2'd2, 0, "fp_hold");
    row(1, 0, 4'b0010, 4'b0000, 2'd2, 0, "fp_release");
    row(1, 0, 4'b0010, 4'b0010, 2'd1, 0, "fp_next");
    row(1, 0, 4'b0000, 4'b0000, 2'd1, 0, "fp_drop");
    row(1, 0, 4'b0000, 4'b0000, 2'd1, 0, "fp_idle2");

    // Round-robin fairness: order 0,1,2,3,0, owner drops req after 2 cycles.
    row(0, 1, 4'b0000, 4'b0000, 2'd0, 0, "rr_rst");
    for (int w = 0; w < 5; w++) begin
      m = 4'b0001 << (w % 4);
      row(1, 1, 4'b1111, m, 2'(w % 4), 0, "rr_grant");
      row(1, 1, 4'b1111, m, 2'(w % 4), 0, "rr_hold");
      row(1, 1, 4'b1111 & ~m, 4'b0000, 2'(w % 4), 0, "rr_release");
    end

    // Hold limit, fixed mode: 8 cycles of grant, revoke pulse, regrant to 0.
    row(0, 0, 4'b0000, 4'b0000, 2'd0, 0, "to_rst");
    for (int i = 0; i < 8; i++) row(1, 0, 4'b0001, 4'b0001, 2'd0, 0, "to_hold");
    row(1, 0, 4'b0001, 4'b0000, 2'd0, 1, "to_revoke");
    row(1, 0, 4'b0001, 4'b0001, 2'd0, 0, "to_regrant");
    row(1, 0, 4'b0000, 4'b0000, 2'd0, 0, "to_release");

    // Hold limit, round-robin: revoked owner 0 yields to requester 1;
    // flipping rr_en while busy leaves the owner alone.
    row(0, 1, 4'b0000, 4'b0000, 2'd0, 0, "tr_rst");
    for (int i = 0; i < 8; i++) row(1, 1, 4'b0011, 4'b0001, 2'd0, 0, "tr_hold");
    row(1, 1, 4'b0011, 4'b0000, 2'd0, 1, "tr_revoke");
    row(1, 1, 4'b0011, 4'b0010, 2'd1, 0, "tr_other");
    row(1, 0, 4'b0011, 4'b0010, 2'd1, 0, "tr_rr_off");
    row(1, 1, 4'b0001, 4'b0000, 2'd1, 0, "tr_rel");

    // No pre-emption: req[3] waits for owner 0 to release.
    row(0, 0, 4'b0000, 4'b0000, 2'd0, 0, "np_rst");
    row(1, 0, 4'b0001, 4'b0001, 2'd0, 0, "np_grant");
    for (int i = 0; i < 3; i++) row(1, 0, 4'b1001, 4'b0001, 2'd0, 0, "np_hold");
    row(1, 0, 4'b1000, 4'b0000, 2'd0, 0, "np_release");
    row(1, 0, 4'b1000, 4'b1000, 2'd3, 0, "np_next");
    row(1, 0, 4'b0000, 4'b0000, 2'd3, 0, "np_done");

    // Reset state.
    rst_n = 1'b0;
    req   = 4'b0000;
    rr_en = 1'b0;
    #12;
    chk_out("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.dut0_gnt", 32'(gnt0), 32'd0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      rr_en = vecs[i].rr_en;
      req   = vecs[i].req;
      @(posedge clk);
      #1;
      chk_out(vecs[i].name, vecs[i].gnt, vecs[i].id, vecs[i].to);
    end

    // Async reset mid-grant drops gnt without a clock edge.
    rst_n = 1'b1;
    rr_en = 1'b0;
    req   = 4'b0100;
    @(posedge clk);
    #1;
    chk_out("ar_grant", 4'b0100, 2'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar_async", 4'b0000, 2'd0, 1'b0);
    req = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_out("ar_idle", 4'b0000, 2'd0, 1'b0);
    end

    // Hold limit disabled: owner 3 keeps the grant for 300 cycles.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b1000;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      chk("nh.gnt", 32'(gnt0), 32'h8);
      chk("nh.timeout", 32'(timeout0), 32'd0);
    end
    chk("nh.gnt_valid", 32'(gnt_valid0), 32'd1);
    chk("nh.gnt_id", 32'(gnt_id0), 32'd3);
    req = 4'b0000;
    @(posedge clk);
    #1;
    chk("nh.release", 32'(gnt0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
